// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: codec-side I2S transmitter with a power-up settle sequence.
// Latency: INIT_FINISH rises INIT_CYCLES edges after INIT is accepted; the first
// sample pair is latched 2*CLK_DIV cycles later, and frames then repeat every 128*CLK_DIV cycles.
// Backpressure: none. data_over tells the controller when to refresh the samples,
// and stale samples are re-sent if it does not.
module audio_i2s_tx #(
  parameter int CLK_DIV     = 8,
  parameter int INIT_CYCLES = 1024
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        INIT,
  input  logic [15:0] LDATA,
  input  logic [15:0] RDATA,
  output logic        INIT_FINISH,
  output logic        data_over,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int SET_W = $clog2(INIT_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INIT_WAIT = 2'd1,
    RUN       = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               finish_q, finish_d;

  logic [DIV_W-1:0]   div_q, div_d;
  logic               bclk_q, bclk_d;
  logic               bclk_fall;

  logic [5:0]         bit_q, bit_d;
  logic [5:0]         bit_nxt;
  logic [15:0]        lsh_q, lsh_d;
  logic [15:0]        rsh_q, rsh_d;
  logic               over_q, over_d;
  logic               lrck_q, lrck_d;
  logic               dat_q, dat_d;

  // Sequencer: IDLE -> INIT_WAIT on INIT, settle count, then RUN until reset.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    finish_d = finish_q;
    unique case (state_q)
      IDLE: begin
        if (INIT) begin
          state_d  = INIT_WAIT;
          settle_d = '0;
        end
      end
      INIT_WAIT: begin
        // INIT is deliberately ignored here so a short pulse still completes.
        if (settle_q == SET_LAST) begin
          state_d  = RUN;
          finish_d = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // BCLK generator: toggle every CLK_DIV cycles, only while running.
  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    if (state_q == RUN) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        bclk_d = ~bclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // A falling BCLK edge happens on the cycle the divider wraps while BCLK is high.
  assign bclk_fall = (state_q == RUN) && (div_q == DIV_LAST) && bclk_q;
  assign bit_nxt   = bit_q + 6'd1;

  // Serializer: every output changes only on a falling BCLK edge, keyed off the new slot number.
  always_comb begin
    bit_d  = bit_q;
    lsh_d  = lsh_q;
    rsh_d  = rsh_q;
    over_d = over_q;
    lrck_d = lrck_q;
    dat_d  = dat_q;
    if (bclk_fall) begin
      bit_d = bit_nxt;
      if (bit_nxt == 6'd0) begin
        // Start of frame: capture both channels so mid-frame input changes are ignored.
        lsh_d  = LDATA;
        rsh_d  = RDATA;
        over_d = 1'b1;
        lrck_d = 1'b0;
        dat_d  = 1'b0;
      end else if (bit_nxt <= 6'd16) begin
        dat_d = lsh_q[15];
        lsh_d = {lsh_q[14:0], 1'b0};
      end else if (bit_nxt == 6'd32) begin
        // Right half begins; the controller may now present the next pair.
        lrck_d = 1'b1;
        over_d = 1'b0;
        dat_d  = 1'b0;
      end else if ((bit_nxt >= 6'd33) && (bit_nxt <= 6'd48)) begin
        dat_d = rsh_q[15];
        rsh_d = {rsh_q[14:0], 1'b0};
      end else begin
        dat_d = 1'b0;
      end
    end
  end

  // State and datapath registers; bit counter resets to 63 so the first fall lands on slot 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      finish_q <= 1'b0;
      div_q    <= '0;
      bclk_q   <= 1'b0;
      bit_q    <= 6'd63;
      lsh_q    <= '0;
      rsh_q    <= '0;
      over_q   <= 1'b0;
      lrck_q   <= 1'b0;
      dat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      finish_q <= finish_d;
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      bit_q    <= bit_d;
      lsh_q    <= lsh_d;
      rsh_q    <= rsh_d;
      over_q   <= over_d;
      lrck_q   <= lrck_d;
      dat_q    <= dat_d;
    end
  end

  assign INIT_FINISH = finish_q;
  assign data_over   = over_q;
  assign AUD_BCLK    = bclk_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dat_q;

endmodule
